multicycle_divider: RTL
=======================

Name: multicycle_divider

Overview:
- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) in the execute stage of JZJCoreF.
- Consumes rs1/rs2 read from the register file.
- Produces a 32-bit result together with rdAddress/writeEnable, which feed the register file write interface.
- Uses restoring division, BITS_PER_CYCLE quotient bits per clock. The control unit stalls on busy.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per iteration cycle. Legal values are 1, 2, 4; any other value is a compile-time error.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clock.
- start  in  1  request; accepted only when busy=0.
- funct3  in  3  3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU; other codes (bit2=0) are treated as DIVU.
- rs1  in  32  dividend.
- rs2  in  32  divisor.
- rdAddressIn  in  5  destination register, latched on accept.
- flush  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  high from the cycle after accept through the DONE cycle inclusive.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  quotient or remainder; holds its value until the next accept.
- rdAddress  out  5  latched destination.
- writeEnable  out  1  equals done. The register file itself suppresses writes to x0.

Behaviour:
- Reset: on posedge clock with reset=1, go to IDLE and clear all registers. busy=0, done=0, writeEnable=0, result=0, rdAddress=0. Reset has priority over start and flush, including mid-operation.
- States: IDLE, DIVIDE, DONE.
- IDLE + start (accept edge):
  - Latch op, rdAddressIn, |rs1|, |rs2| (magnitudes only for signed ops) and the result signs.
  - Quotient sign = rs1[31]^rs2[31]; remainder sign = rs1[31].
  - Special cases go straight to DONE:
    - rs2=0: quotient=32'hFFFFFFFF, remainder=rs1 (signed and unsigned).
    - Signed op with rs1=32'h80000000 and rs2=32'hFFFFFFFF: quotient=32'h80000000, remainder=0.
  - Otherwise go to DIVIDE with iteration counter=0.
- DIVIDE:
  - Each cycle performs BITS_PER_CYCLE restoring steps: shift the {remainder,dividend} pair left, trial-subtract the divisor, set the quotient bit when the difference is non-negative.
  - Remainder accumulator is 33 bits wide.
  - Counter increments by 1. After 32/BITS_PER_CYCLE cycles, go to DONE.
- DONE:
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Select quotient (funct3[1]=0) or remainder (funct3[1]=1) into result.
  - done=1 and writeEnable=1 for exactly this cycle; next state is IDLE.
- Latency, accept edge to done high:
  - Special case: 1 cycle.
  - Normal case: 32/BITS_PER_CYCLE + 1 cycles (33 at default).
- start while busy=1, including the DONE cycle: ignored, with no effect on state.
- Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.
- flush=1 (no reset):
  - In DIVIDE or DONE: next state IDLE; done and writeEnable forced 0 in that cycle; result keeps its previous value.
  - flush and start together in IDLE: flush wins, nothing is accepted.
- Signed magnitude of 32'h80000000 is 32'h80000000 treated as unsigned; no overflow inside the datapath.

Decomposition:
- Shared package divider_pkg:
  - funct3 constants: FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU.
  - State enum divider_state_t {IDLE, DIVIDE, DONE}.
  - Constant XLEN=32.
- One combinational sub-module, divider_step: a single restoring step (33-bit remainder, 32-bit divisor, shift-in bit → new remainder, quotient bit). It is instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- DIVU rs1=100, rs2=7, rdAddressIn=5 → done exactly 33 cycles after accept; result=14, rdAddress=5, writeEnable=1 for 1 cycle; REMU with the same operands → 2.
- DIV rs1=-7 (32'hFFFFFFF9), rs2=2 → result=32'hFFFFFFFD (-3); REM → 32'hFFFFFFFF (-1); REM rs1=7, rs2=-2 → 1.
- DIV rs1=1234, rs2=0 → done 1 cycle after accept, result=32'hFFFFFFFF; REMU same operands → 1234.
- DIV rs1=32'h80000000, rs2=32'hFFFFFFFF → result=32'h80000000 after 1 cycle; REM → 0.
- Flush at cycle 10 of DIVIDE → busy=0 next cycle, done never pulses. Second start asserted while busy is ignored; the first op's result is unchanged.
- Reset asserted at cycle 20 of DIVIDE → next cycle busy=0, done=0, result=0. A new DIVU 50/5 accepted afterwards → 10 after 33 cycles. BITS_PER_CYCLE=4 build → same result after 9 cycles.

Source files
------------

// File: rtl/multicycle_divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package divider_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } divider_state_t;

  function automatic logic [XLEN-1:0] neg_if(
    input logic            n,
    input logic [XLEN-1:0] v
  );
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multicycle_divider_if.sv
// Request/response bundle between execute control and the divider.
interface multicycle_divider_if;
  import divider_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rdAddressIn;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rdAddress;
  logic            writeEnable;

  modport master (
    output start, funct3, rs1, rs2,
    output rdAddressIn, flush,
    input  busy, done, result,
    input  rdAddress, writeEnable
  );

  modport slave (
    input  start, funct3, rs1, rs2,
    input  rdAddressIn, flush,
    output busy, done, result,
    output rdAddress, writeEnable
  );

endinterface

// File: rtl/multicycle_divider_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract.
module divider_step
  import divider_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] dvs_i,
  input  logic            bit_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {2'b00, dvs_i};
  assign q_o     = ~diff[XLEN+1];
  assign rem_o   = q_o ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/multicycle_divider.sv
// Iterative DIV/DIVU/REM/REMU unit; restoring, BITS_PER_CYCLE bits/clock.
module multicycle_divider
  import divider_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                 clock,
  input logic                 reset,
  multicycle_divider_if.slave dif
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS);
  localparam int B     = BITS_PER_CYCLE;

  if (!(B == 1 || B == 2 || B == 4)) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2 or 4");
  end

  divider_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic            sel_q, sel_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            done;

  logic [B:0][XLEN:0] chain;
  logic [B-1:0]       qbits;

  assign chain[0] = rem_q;

  for (genvar g = 0; g < B; g++) begin : g_step
    divider_step u_step (
      .rem_i (chain[g]),
      .dvs_i (dvs_q),
      .bit_i (quo_q[XLEN-1-g]),
      .rem_o (chain[g+1]),
      .q_o   (qbits[B-1-g])
    );
  end

  logic            sgn_op, rem_op, ovf;
  logic [XLEN-1:0] a_mag, b_mag, fin;

  assign sgn_op = dif.funct3[2] & ~dif.funct3[0];
  assign rem_op = dif.funct3[2] & dif.funct3[1];
  assign a_mag  = neg_if(sgn_op & dif.rs1[XLEN-1], dif.rs1);
  assign b_mag  = neg_if(sgn_op & dif.rs2[XLEN-1], dif.rs2);
  assign ovf    = sgn_op && dif.rs1 == 32'h8000_0000
                  && dif.rs2 == 32'hFFFF_FFFF;
  assign fin    = sel_q ? neg_if(rneg_q, rem_q[XLEN-1:0])
                        : neg_if(qneg_q, quo_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    rd_d    = rd_q;
    sel_d   = sel_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dif.start && !dif.flush) begin
          rd_d   = dif.rdAddressIn;
          sel_d  = rem_op;
          dvs_d  = b_mag;
          cnt_d  = '0;
          qneg_d = 1'b0;
          rneg_d = 1'b0;
          // special cases park final values so DONE needs no extra path
          if (dif.rs2 == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dif.rs1};
            state_d = DONE;
          end else if (ovf) begin
            quo_d   = 32'h8000_0000;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            qneg_d  = sgn_op & (dif.rs1[XLEN-1] ^ dif.rs2[XLEN-1]);
            rneg_d  = sgn_op & dif.rs1[XLEN-1];
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (dif.flush) begin
          state_d = IDLE;
        end else begin
          rem_d = chain[B];
          quo_d = {quo_q[XLEN-1-B:0], qbits};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ITERS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!dif.flush) begin
          done  = 1'b1;
          res_d = fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      sel_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign dif.busy        = state_q != IDLE;
  assign dif.done        = done;
  assign dif.writeEnable = done;
  assign dif.result      = done ? fin : res_q;
  assign dif.rdAddress   = rd_q;

endmodule
